// File: rtl/mult_div_seq.sv
// Multicycle signed MULT/DIV sequencer feeding HI/LO.
// Shift-add multiply or restoring divide over WIDTH iterations.
module mult_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic               op_q;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic               dz_req;

  assign a_abs  = a[WIDTH-1] ? -a : a;
  assign b_abs  = b[WIDTH-1] ? -b : b;
  assign dz_req = op && (b == '0);

  assign busy = (state == CALC) || (state == SIGN);
  assign done = (state == DONE);

  // One multiply step: add multiplicand on LSB, shift {carry, acc} right.
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] mul_nx;

  assign addend = mplier[0] ? mag_a : '0;
  assign msum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign mul_nx = {msum, acc[WIDTH-1:1]};

  // One restoring divide step; shifted remainder needs WIDTH+1 bits.
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_sub;
  logic               take;
  logic [2*WIDTH-1:0] div_nx;

  assign rem_sh  = acc[2*WIDTH-1:WIDTH-1];
  assign rem_sub = rem_sh[WIDTH-1:0] - mag_b;
  assign take    = rem_sh >= {1'b0, mag_b};
  assign div_nx  = take ? {rem_sub, acc[WIDTH-2:0], 1'b1}
                        : {acc[2*WIDTH-2:0], 1'b0};

  // Sign correction of the finished magnitude result.
  logic               neg;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;

  always_comb begin
    neg  = sign_a ^ sign_b;
    prod = neg ? -acc : acc;
    if (op_q) begin
      fin_lo = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      fin_hi = sign_a ? -acc[2*WIDTH-1:WIDTH]
                      : acc[2*WIDTH-1:WIDTH];
    end else begin
      fin_hi = prod[2*WIDTH-1:WIDTH];
      fin_lo = prod[WIDTH-1:0];
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = dz_req ? DONE : CALC;
      CALC: if (cnt == '0) state_nx = SIGN;
      SIGN: state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand latch, iterations, result writeback.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q     <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      mag_a    <= '0;
      mag_b    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && dz_req) begin
            div_zero <= 1'b1;
          end else if (start) begin
            op_q   <= op;
            sign_a <= a[WIDTH-1];
            sign_b <= b[WIDTH-1];
            mag_a  <= a_abs;
            mag_b  <= b_abs;
            mplier <= b_abs;
            acc    <= op ? {{WIDTH{1'b0}}, a_abs} : '0;
            cnt    <= CW'(WIDTH - 1);
          end
        end
        CALC: begin
          acc    <= op_q ? div_nx : mul_nx;
          mplier <= mplier >> 1;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        SIGN: begin
          hi <= fin_hi;
          lo <= fin_lo;
        end
        DONE: div_zero <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// Bench for mult_div_seq: vector table, scoreboard queue,
// plus ignored-start and mid-operation reset sequences.
module tb_mult_div_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  mult_div_seq #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  vec_t tv[13];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic o, input logic [31:0] x,
                                input logic [31:0] y,
                                output logic [31:0] h,
                                output logic [31:0] l);
    longint sx, sy;
    logic [63:0] p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!o) begin
      p = sx * sy;
      h = p[63:32];
      l = p[31:0];
    end else begin
      q = sx / sy;
      r = sx % sy;
      l = q[31:0];
      h = r[31:0];
    end
  endfunction

  task automatic run(input vec_t v, input int inj);
    exp_t e;
    int   n;
    int   bn;
    e.hi = v.hi;
    e.lo = v.lo;
    e.dz = v.dz;
    sb.push_back(e);
    @(negedge clock);
    op = v.op; a = v.a; b = v.b; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 1'($urandom_range(1));
    n = 1;
    bn = 0;
    while (!done && n < 100) begin
      if (busy) bn++;
      start = (n == inj);
      if (n == inj) begin
        op = 1'b1;
        b = '0;
      end
      @(negedge clock);
      n++;
    end
    start = 1'b0;
    e = sb.pop_front();
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done after %0d cycles", n);
    end else begin
      chk("hi", hi, e.hi);
      chk("lo", lo, e.lo);
      chk("div_zero", 32'(div_zero), 32'(e.dz));
      chk("latency", n, e.dz ? 1 : 34);
      chk("busy_cycles", bn, e.dz ? 0 : 33);
      @(negedge clock);
      chk("done_pulse", 32'(done), 0);
      chk("div_zero_clear", 32'(div_zero), 0);
    end
  endtask

  initial begin
    vec_t v;
    logic [31:0] h, l;

    tv[0] = '{1'b0, 32'd7, 32'hFFFFFFFD,
              32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    tv[1] = '{1'b0, 32'h80000000, 32'h80000000,
              32'h40000000, 32'h00000000, 1'b0};
    tv[2] = '{1'b0, 32'd0, 32'h12345678,
              32'h0, 32'h0, 1'b0};
    tv[3] = '{1'b1, 32'hFFFFFFF9, 32'd2,
              32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    tv[4] = '{1'b1, 32'd7, 32'hFFFFFFFE,
              32'd1, 32'hFFFFFFFD, 1'b0};
    tv[5] = '{1'b1, 32'h80000000, 32'hFFFFFFFF,
              32'h0, 32'h80000000, 1'b0};
    tv[6] = '{1'b1, 32'd5, 32'd0,
              32'h0, 32'h80000000, 1'b1};
    for (int i = 7; i < 13; i++) begin
      v.op = 1'(i & 1);
      v.a  = $urandom;
      v.b  = $urandom;
      if (i == 9) v.b = 32'(-$urandom_range(300, 1));
      if (v.b == 0) v.b = 32'd3;
      model(v.op, v.a, v.b, h, l);
      v.hi = h;
      v.lo = l;
      v.dz = 1'b0;
      tv[i] = v;
    end

    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_dz", 32'(div_zero), 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    reset = 1'b1;
    @(negedge clock);
    chk("idle_done", 32'(done), 0);

    for (int i = 0; i < 13; i++) run(tv[i], 0);

    run(tv[0], 5);

    @(negedge clock);
    op = 1'b0; a = 32'h1234; b = 32'h5678; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_dz", 32'(div_zero), 0);
    chk("mid_rst_hi", hi, 0);
    chk("mid_rst_lo", lo, 0);
    @(negedge clock);
    reset = 1'b1;
    v = '{1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0};
    run(v, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
